// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage feeding the sequence detector's x input.
// A holding register double-buffers words so consecutive words stream without a gap.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             bit_tick,
  output logic             frame_done,
  output logic             busy
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

  if (WIDTH < 2 || DIV < 1) begin : g_param_check
    $error("bit_serializer: WIDTH must be >= 2 and DIV must be >= 1");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] hr, sr, sr_next;
  logic             hr_valid;
  logic [BCW-1:0]   bit_cnt, bit_next;
  logic [DCW-1:0]   div_cnt, div_next;
  logic             x_next, x_valid_next, bit_tick_next, frame_done_next;
  logic             accept, bit_end, word_end, load, advance;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign din_ready = !hr_valid && !rst;
  assign busy      = (state == SHIFT) || hr_valid;
  assign accept    = din_valid && din_ready;
  assign bit_end   = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign word_end  = bit_end && (bit_cnt == BIT_LAST);
  // A buffered word moves into SR either from idle or exactly at a word boundary.
  assign load      = hr_valid && ((state == IDLE) || word_end);
  assign advance   = bit_end && !word_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hr       <= '0;
      hr_valid <= 1'b0;
    end else if (accept) begin
      hr       <= din;
      hr_valid <= 1'b1;
    end else if (load) begin
      hr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      x          <= IDLE_BIT;
      x_valid    <= 1'b0;
      bit_tick   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      sr         <= sr_next;
      bit_cnt    <= bit_next;
      div_cnt    <= div_next;
      x          <= x_next;
      x_valid    <= x_valid_next;
      bit_tick   <= bit_tick_next;
      frame_done <= frame_done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hr_valid) state_next = SHIFT;
      SHIFT:   if (word_end && !hr_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sr_next         = sr;
    bit_next        = bit_cnt;
    div_next        = div_cnt;
    x_next          = x;
    x_valid_next    = x_valid;
    bit_tick_next   = 1'b0;
    frame_done_next = word_end;
    if (load) begin
      sr_next       = hr;
      bit_next      = '0;
      div_next      = '0;
      x_next        = first_bit(hr);
      x_valid_next  = 1'b1;
      bit_tick_next = 1'b1;
    end else if (advance) begin
      sr_next       = shifted(sr);
      bit_next      = bit_cnt + 1'b1;
      div_next      = '0;
      x_next        = first_bit(shifted(sr));
      bit_tick_next = 1'b1;
    end else if (state == SHIFT && !word_end) begin
      div_next = div_cnt + 1'b1;
    end else begin
      bit_next     = '0;
      div_next     = '0;
      x_next       = IDLE_BIT;
      x_valid_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: three serializer configurations checked against directed
// vectors, hand-written corner sequences and a word/time-index reference model.
module tb_bit_serializer;

  localparam int W = 4;
  localparam int DIVS  [3] = '{1, 3, 2};
  localparam bit MSBS  [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit IDLES [3] = '{1'b0, 1'b0, 1'b1};

  logic         clk;
  logic         rst;
  logic [W-1:0] din        [3];
  logic         din_valid  [3];
  logic         din_ready  [3];
  logic         x          [3];
  logic         x_valid    [3];
  logic         bit_tick   [3];
  logic         frame_done [3];
  logic         busy       [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit cap_en = 1'b0;
  bit cap_q[$];
  bit took [3];

  bit_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .x(x[0]), .x_valid(x_valid[0]), .bit_tick(bit_tick[0]), .frame_done(frame_done[0]), .busy(busy[0]));

  bit_serializer #(.WIDTH(W), .DIV(3), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .x(x[1]), .x_valid(x_valid[1]), .bit_tick(bit_tick[1]), .frame_done(frame_done[1]), .busy(busy[1]));

  bit_serializer #(.WIDTH(W), .DIV(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_c (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
    .x(x[2]), .x_valid(x_valid[2]), .bit_tick(bit_tick[2]), .frame_done(frame_done[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the word in flight is tracked only by a cycle index t since its
  // first bit; the bit on x is word bit t/DIV and a word lasts WIDTH*DIV cycles.
  typedef struct {
    bit          active;
    int unsigned word;
    int          t;
    bit          hr_full;
    int unsigned hr_word;
    bit          fd;
  } model_t;

  model_t mdl [3];

  function automatic model_t model_step(model_t m, int div, bit dv, logic [W-1:0] d);
    model_t n = m;
    bit ready = !m.hr_full;
    n.fd = 1'b0;
    if (n.active) begin
      n.t++;
      if (n.t == W * div) begin
        n.active = 1'b0;
        n.fd     = 1'b1;
      end
    end
    if (!n.active && n.hr_full) begin
      n.active  = 1'b1;
      n.word    = n.hr_word;
      n.t       = 0;
      n.hr_full = 1'b0;
    end
    if (dv && ready) begin
      n.hr_full = 1'b1;
      n.hr_word = 32'(d);
    end
    return n;
  endfunction

  function automatic logic [5:0] model_out(model_t m, int div, bit msb, bit idle, bit r);
    int k;
    logic xb;
    xb = idle;
    if (m.active) begin
      k  = m.t / div;
      xb = msb ? m.word[W-1-k] : m.word[k];
    end
    return {xb, m.active, m.active && (m.t % div == 0), m.fd, !m.hr_full && !r, m.active || m.hr_full};
  endfunction

  function automatic logic [5:0] dut_out(int i);
    return {x[i], x_valid[i], bit_tick[i], frame_done[i], din_ready[i], busy[i]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) mdl[i] <= '{default: 0};
    end else begin
      for (int i = 0; i < 3; i++) mdl[i] <= model_step(mdl[i], DIVS[i], din_valid[i], din[i]);
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic dv, input logic [W-1:0] d);
    @(negedge clk);
    din_valid[i] = dv;
    din[i]       = d;
  endtask

  task automatic sampleEdge();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      for (int i = 0; i < 3; i++)
        checkOutput($sformatf("model dut%0d t=%0t", i, $time), {10'b0, dut_out(i)},
                    {10'b0, model_out(mdl[i], DIVS[i], MSBS[i], IDLES[i], rst)});
    end
  end

  always @(posedge clk) begin
    #2;
    if (cap_en && x_valid[1] && bit_tick[1]) cap_q.push_back(x[1]);
  end

  typedef struct {
    logic         dv;
    logic [W-1:0] d;
    logic [5:0]   exp;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] got;
    logic [W-1:0] bp_words [3];
    int ticks;
    bit accepted;

    // {x, x_valid, bit_tick, frame_done, din_ready, busy}: back-to-back B,3 then a lone B.
    tbl[0]  = '{1'b1, 4'hB, 6'b000001};
    tbl[1]  = '{1'b1, 4'h3, 6'b111011};
    tbl[2]  = '{1'b1, 4'h3, 6'b011001};
    tbl[3]  = '{1'b0, 4'h0, 6'b111001};
    tbl[4]  = '{1'b0, 4'h0, 6'b111001};
    tbl[5]  = '{1'b0, 4'h0, 6'b011111};
    tbl[6]  = '{1'b0, 4'h0, 6'b011011};
    tbl[7]  = '{1'b0, 4'h0, 6'b111011};
    tbl[8]  = '{1'b0, 4'h0, 6'b111011};
    tbl[9]  = '{1'b0, 4'h0, 6'b000110};
    tbl[10] = '{1'b0, 4'h0, 6'b000010};
    tbl[11] = '{1'b1, 4'hB, 6'b000001};
    tbl[12] = '{1'b0, 4'h0, 6'b111011};
    tbl[13] = '{1'b0, 4'h0, 6'b011011};
    tbl[14] = '{1'b0, 4'h0, 6'b111011};
    tbl[15] = '{1'b0, 4'h0, 6'b111011};
    tbl[16] = '{1'b0, 4'h0, 6'b000110};
    tbl[17] = '{1'b0, 4'h0, 6'b000010};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[i]       = '0;
      din_valid[i] = 1'b0;
      took[i]      = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("reset dut%0d", i), {10'b0, dut_out(i)}, {10'b0, IDLES[i], 5'b00000});
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    for (int r = 0; r < 18; r++) begin
      applyStimulus(0, tbl[r].dv, tbl[r].d);
      sampleEdge();
      checkOutput($sformatf("table row%0d", r), {10'b0, dut_out(0)}, {10'b0, tbl[r].exp});
    end

    // DIV=3: each bit of 1001 held three cycles, one tick per bit.
    w = 4'b1001;
    applyStimulus(1, 1'b1, w);
    sampleEdge();
    checkOutput("div3 latency", {10'b0, dut_out(1)}, {10'b0, 6'b000001});
    applyStimulus(1, 1'b0, 4'h0);
    ticks = 0;
    for (int c = 0; c <= 12; c++) begin
      sampleEdge();
      if (bit_tick[1]) ticks++;
      checkOutput($sformatf("div3 c%0d", c), {10'b0, dut_out(1)},
                  {10'b0, (c < 12) ? {w[W-1-c/3], 1'b1, (c % 3) == 0, 3'b011} : 6'b000110});
    end
    checkOutput("div3 tick count", 16'(ticks), 16'd4);

    // LSB-first, DIV=2, idle level high: 1011 -> 1,1,0,1.
    w = 4'b1011;
    applyStimulus(2, 1'b1, w);
    sampleEdge();
    checkOutput("lsb latency", {10'b0, dut_out(2)}, {10'b0, 6'b100001});
    applyStimulus(2, 1'b0, 4'h0);
    for (int c = 0; c <= 8; c++) begin
      sampleEdge();
      checkOutput($sformatf("lsb c%0d", c), {10'b0, dut_out(2)},
                  {10'b0, (c < 8) ? {w[c/2], 1'b1, (c % 2) == 0, 3'b011} : 6'b100110});
    end

    // Backpressure: third word held while HR is full; stream must be A,5,C exactly once.
    bp_words[0] = 4'hA;
    bp_words[1] = 4'h5;
    bp_words[2] = 4'hC;
    cap_q.delete();
    cap_en = 1'b1;
    applyStimulus(1, 1'b1, bp_words[0]);
    sampleEdge();
    applyStimulus(1, 1'b1, bp_words[1]);
    sampleEdge();
    applyStimulus(1, 1'b1, bp_words[1]);
    sampleEdge();
    applyStimulus(1, 1'b1, bp_words[2]);
    for (int c = 0; c < 6; c++) begin
      sampleEdge();
      checkOutput($sformatf("bp ready low c%0d", c), {15'b0, din_ready[1]}, 16'd0);
    end
    accepted = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) begin
      if (din_ready[1]) begin
        sampleEdge();
        applyStimulus(1, 1'b0, 4'h0);
        accepted = 1'b1;
      end else begin
        sampleEdge();
      end
    end
    checkOutput("bp accept within bound", {15'b0, accepted}, 16'd1);
    for (int c = 0; c < 30; c++) sampleEdge();
    cap_en = 1'b0;
    checkOutput("bp bit count", 16'(cap_q.size()), 16'd12);
    if (cap_q.size() >= 12) begin
      for (int k = 0; k < 3; k++) begin
        for (int b = 0; b < W; b++) got[W-1-b] = cap_q[k*W + b];
        checkOutput($sformatf("bp word%0d", k), {12'b0, got}, {12'b0, bp_words[k]});
      end
    end

    // One-cycle reset in the middle of a word with HR occupied.
    applyStimulus(0, 1'b1, 4'hB);
    sampleEdge();
    applyStimulus(0, 1'b1, 4'h6);
    sampleEdge();
    applyStimulus(0, 1'b1, 4'h6);
    sampleEdge();
    @(negedge clk);
    rst          = 1'b1;
    din_valid[0] = 1'b0;
    #1;
    checkOutput("reset immediate", {10'b0, dut_out(0)}, {10'b0, 6'b000000});
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset release", {10'b0, dut_out(0)}, {10'b0, 6'b000010});
    for (int c = 0; c < 6; c++) begin
      sampleEdge();
      checkOutput($sformatf("no residual c%0d", c), {10'b0, dut_out(0)}, {10'b0, 6'b000010});
    end
    w = 4'h6;
    applyStimulus(0, 1'b1, w);
    sampleEdge();
    applyStimulus(0, 1'b0, 4'h0);
    for (int c = 0; c <= 4; c++) begin
      sampleEdge();
      checkOutput($sformatf("post reset c%0d", c), {10'b0, dut_out(0)},
                  {10'b0, (c < 4) ? {w[W-1-c], 5'b11011} : 6'b000110});
    end

    // Random producers on all three instances with occasional reset pulses.
    for (int i = 0; i < 3; i++) took[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!din_valid[i] || took[i]) begin
          din_valid[i] = ($urandom_range(0, 3) != 0);
          din[i]       = W'($urandom);
        end
      end
      #1;
      for (int i = 0; i < 3; i++) took[i] = din_valid[i] && din_ready[i];
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) din_valid[i] = 1'b0;
    for (int c = 0; c < 40; c++) sampleEdge();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
